// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//
// Hardwired Moore control sequencer for the 32-bit register-bus datapath.
// Each instruction is a 3-step fetch (T0..T2) followed by class-specific
// execute steps (T3..T7). The state is registered; every strobe is decoded
// combinationally from the state and the instruction register.
//
// Ports
//   clk       : sole clock, state changes on the rising edge
//   clr       : asynchronous, active-low reset (forces RST, all strobes 0)
//   IR        : instruction register contents read back from the datapath
//   Stop      : halt request, only honoured on entry to T0
//   PCout .. Cout : single-bit datapath strobes
//   Rin/Rout  : one-hot (or zero) general-register load / bus-drive enables
//   OpCode    : ALU function select
//   Csx       : sign-extended IR[18:0], bus source whenever Cout=1
//   Run       : high while the sequencer is stepping T0..T7
//
// Debug visibility: the FSM state lives in state_q (type state_t), which a
// checker can bind to or probe hierarchically.
// ---------------------------------------------------------------------------
module control_unit #(
    parameter logic [4:0] ALU_ADD = 5'b00011,
    parameter logic [4:0] ALU_SUB = 5'b00100,
    parameter logic [4:0] ALU_AND = 5'b00101,
    parameter logic [4:0] ALU_OR  = 5'b00110,
    parameter logic [4:0] ALU_MUL = 5'b01110,
    parameter logic [4:0] ALU_DIV = 5'b01111,
    parameter logic [4:0] ALU_INC = 5'b10100
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic        Cout,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [4:0]  OpCode,
    output logic [31:0] Csx,
    output logic        Run
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_HALT = 5'b11001;

    state_t state_q, state_d;

    // Instruction fields and class decode (meaningful from T3 onward).
    logic [4:0]  op;
    logic [15:0] ra_hot, rb_hot, rc_hot;
    logic        is_alu, is_md, is_ld, is_st, is_mem, is_halt;
    logic [4:0]  alu_code;
    state_t      boundary_state;

    assign op     = IR[31:27];
    assign ra_hot = 16'h0001 << IR[26:23];
    assign rb_hot = 16'h0001 << IR[22:19];
    assign rc_hot = 16'h0001 << IR[18:15];

    assign is_alu  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    assign is_md   = (op == OP_MUL) || (op == OP_DIV);
    assign is_ld   = (op == OP_LD);
    assign is_st   = (op == OP_ST);
    assign is_mem  = is_ld || is_st;
    assign is_halt = (op == OP_HALT);

    assign Csx = {{13{IR[18]}}, IR[18:0]};

    always_comb begin
        alu_code = 5'b00000;
        case (op)
            OP_ADD:  alu_code = ALU_ADD;
            OP_SUB:  alu_code = ALU_SUB;
            OP_AND:  alu_code = ALU_AND;
            OP_OR:   alu_code = ALU_OR;
            OP_MUL:  alu_code = ALU_MUL;
            OP_DIV:  alu_code = ALU_DIV;
            default: alu_code = 5'b00000;
        endcase
    end

    // Every entry into T0 is an instruction boundary, where Stop diverts
    // the sequencer into HALT instead.
    assign boundary_state = Stop ? S_HALT : S_T0;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:   state_d = boundary_state;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3: begin
                if (is_alu || is_md || is_mem) state_d = S_T4;
                else if (is_halt)              state_d = S_HALT;
                else                           state_d = boundary_state;
            end
            S_T4:    state_d = S_T5;
            S_T5:    state_d = is_alu ? boundary_state : S_T6;
            S_T6:    state_d = is_md ? boundary_state : S_T7;
            S_T7:    state_d = boundary_state;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        PCout    = 1'b0;
        PCin     = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        Read     = 1'b0;
        Write    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Cout     = 1'b0;
        Rin      = 16'h0000;
        Rout     = 16'h0000;
        OpCode   = 5'b00000;
        Run      = 1'b0;
        case (state_q)
            S_T0: begin
                Run    = 1'b1;
                PCout  = 1'b1;
                MARin  = 1'b1;
                OpCode = ALU_INC;
                Zin    = 1'b1;
            end
            S_T1: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                Run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Run = 1'b1;
                // mul/div take Ra into Y; register ALU and address forms take Rb.
                if (is_md) begin
                    Rout = ra_hot;
                    Yin  = 1'b1;
                end else if (is_alu || is_mem) begin
                    Rout = rb_hot;
                    Yin  = 1'b1;
                end
            end
            S_T4: begin
                Run = 1'b1;
                Zin = 1'b1;
                if (is_mem) begin
                    Cout   = 1'b1;
                    OpCode = ALU_ADD;
                end else begin
                    Rout   = is_md ? rb_hot : rc_hot;
                    OpCode = alu_code;
                end
            end
            S_T5: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                if (is_alu)     Rin   = ra_hot;
                else if (is_md) LOin  = 1'b1;
                else            MARin = 1'b1;
            end
            S_T6: begin
                Run = 1'b1;
                if (is_md) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end else if (is_ld) begin
                    Read  = 1'b1;
                    MDRin = 1'b1;
                end else begin
                    // Read stays low so MDR captures Ra from the bus.
                    Rout  = ra_hot;
                    MDRin = 1'b1;
                end
            end
            S_T7: begin
                Run = 1'b1;
                if (is_ld) begin
                    MDRout = 1'b1;
                    Rin    = ra_hot;
                end else begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//
// Table-driven bench for control_unit. Each row holds the IR/Stop inputs
// for one cycle and the hand-computed strobes expected in that cycle.
// Hand-written sequences cover mid-instruction reset, the halt opcode and
// the sign extension of the constant field.
// ---------------------------------------------------------------------------
module tb_control_unit;

    // Strobe bundle bit positions, MSB first: PCout .. Cout, Run.
    localparam logic [15:0] S_PCOUT    = 16'h8000;
    localparam logic [15:0] S_PCIN     = 16'h4000;
    localparam logic [15:0] S_MARIN    = 16'h2000;
    localparam logic [15:0] S_MDRIN    = 16'h1000;
    localparam logic [15:0] S_MDROUT   = 16'h0800;
    localparam logic [15:0] S_READ     = 16'h0400;
    localparam logic [15:0] S_WRITE    = 16'h0200;
    localparam logic [15:0] S_IRIN     = 16'h0100;
    localparam logic [15:0] S_YIN      = 16'h0080;
    localparam logic [15:0] S_ZIN      = 16'h0040;
    localparam logic [15:0] S_ZLOWOUT  = 16'h0020;
    localparam logic [15:0] S_ZHIGHOUT = 16'h0010;
    localparam logic [15:0] S_HIIN     = 16'h0008;
    localparam logic [15:0] S_LOIN     = 16'h0004;
    localparam logic [15:0] S_COUT     = 16'h0002;
    localparam logic [15:0] S_RUN      = 16'h0001;

    logic        clk, clr, Stop;
    logic [31:0] IR;
    logic        PCout, PCin, MARin, MDRin, MDRout, Read, Write, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout, Run;
    logic [15:0] Rin, Rout;
    logic [4:0]  OpCode;
    logic [31:0] Csx;

    control_unit dut (
        .clk(clk), .clr(clr), .IR(IR), .Stop(Stop),
        .PCout(PCout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .HIin(HIin), .LOin(LOin), .Cout(Cout),
        .Rin(Rin), .Rout(Rout), .OpCode(OpCode), .Csx(Csx), .Run(Run)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic        stop;
        logic [15:0] strobes;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  opc;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] mk_ir(logic [4:0] op, logic [3:0] ra,
                                          logic [3:0] rb, logic [18:0] c);
        return {op, ra, rb, c};
    endfunction

    task automatic add_v(string n, logic [31:0] ir, logic stop, logic [15:0] s,
                         logic [15:0] rin, logic [15:0] rout, logic [4:0] opc);
        vec_t v;
        v.name = n; v.ir = ir; v.stop = stop; v.strobes = s;
        v.rin = rin; v.rout = rout; v.opc = opc;
        vecs.push_back(v);
    endtask

    task automatic add_fetch(string n, logic [31:0] ir);
        add_v({n, "_t0"}, ir, 1'b0, S_RUN | S_PCOUT | S_MARIN | S_ZIN, 16'h0, 16'h0, 5'b10100);
        add_v({n, "_t1"}, ir, 1'b0, S_RUN | S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN, 16'h0, 16'h0, 5'b00000);
        add_v({n, "_t2"}, ir, 1'b0, S_RUN | S_MDROUT | S_IRIN, 16'h0, 16'h0, 5'b00000);
    endtask

    // Scoreboard compare of the full output bundle against one expectation.
    task automatic check_outs(string n, logic [15:0] s, logic [15:0] rin,
                              logic [15:0] rout, logic [4:0] opc);
        logic [15:0] act_s;
        act_s = {PCout, PCin, MARin, MDRin, MDRout, Read, Write, IRin,
                 Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout, Run};
        checks++;
        if (act_s !== s || Rin !== rin || Rout !== rout || OpCode !== opc) begin
            errors++;
            $display("FAIL %s: got strobes=%h Rin=%h Rout=%h OpCode=%b, want strobes=%h Rin=%h Rout=%h OpCode=%b",
                     n, act_s, Rin, Rout, OpCode, s, rin, rout, opc);
        end
    endtask

    task automatic check_csx(string n, logic [31:0] exp);
        checks++;
        if (Csx !== exp) begin
            errors++;
            $display("FAIL %s: got Csx=%h want %h", n, Csx, exp);
        end
    endtask

    // Driver: one table row per falling edge, compared just after.
    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            IR   = vecs[i].ir;
            Stop = vecs[i].stop;
            #1;
            check_outs(vecs[i].name, vecs[i].strobes, vecs[i].rin, vecs[i].rout, vecs[i].opc);
        end
    endtask

    logic [31:0] ir_add, ir_sub, ir_and, ir_or, ir_mul, ir_div, ir_ld, ir_st;
    logic [31:0] ir_nop, ir_und, ir_add2, ir_halt;

    initial begin
        ir_add  = 32'h18A18000;                                  // add R1,R4,R3
        ir_sub  = mk_ir(5'b00100, 4'd0, 4'd15, {4'd1, 15'd0});   // sub R0,R15,R1
        ir_and  = mk_ir(5'b00101, 4'd3, 4'd1, {4'd2, 15'd0});    // and R3,R1,R2
        ir_or   = mk_ir(5'b00110, 4'd15, 4'd14, {4'd13, 15'd0}); // or R15,R14,R13
        ir_mul  = 32'h72B00000;                                  // mul R5,R6
        ir_div  = mk_ir(5'b01111, 4'd15, 4'd0, 19'd0);           // div R15,R0
        ir_ld   = mk_ir(5'b00000, 4'd2, 4'd7, 19'h7FFFF);        // ld R2,-1(R7)
        ir_st   = mk_ir(5'b00010, 4'd9, 4'd0, 19'h00010);        // st R9,0x10(R0)
        ir_nop  = mk_ir(5'b11000, 4'd1, 4'd2, 19'd0);
        ir_und  = mk_ir(5'b10001, 4'd1, 4'd2, {4'd3, 15'd0});
        ir_add2 = mk_ir(5'b00011, 4'd6, 4'd2, {4'd10, 15'd0});   // add R6,R2,R10
        ir_halt = mk_ir(5'b11001, 4'd0, 4'd0, 19'd0);

        // Vector table
        add_fetch("add", ir_add);
        add_v("add_t3", ir_add, 1'b0, S_RUN | S_YIN, 16'h0, 16'h0010, 5'b00000);
        add_v("add_t4", ir_add, 1'b0, S_RUN | S_ZIN, 16'h0, 16'h0008, 5'b00011);
        add_v("add_t5", ir_add, 1'b0, S_RUN | S_ZLOWOUT, 16'h0002, 16'h0, 5'b00000);

        add_fetch("sub", ir_sub);
        add_v("sub_t3", ir_sub, 1'b0, S_RUN | S_YIN, 16'h0, 16'h8000, 5'b00000);
        add_v("sub_t4", ir_sub, 1'b0, S_RUN | S_ZIN, 16'h0, 16'h0002, 5'b00100);
        add_v("sub_t5", ir_sub, 1'b0, S_RUN | S_ZLOWOUT, 16'h0001, 16'h0, 5'b00000);

        add_fetch("and", ir_and);
        add_v("and_t3", ir_and, 1'b0, S_RUN | S_YIN, 16'h0, 16'h0002, 5'b00000);
        add_v("and_t4", ir_and, 1'b0, S_RUN | S_ZIN, 16'h0, 16'h0004, 5'b00101);
        add_v("and_t5", ir_and, 1'b0, S_RUN | S_ZLOWOUT, 16'h0008, 16'h0, 5'b00000);

        add_fetch("or", ir_or);
        add_v("or_t3", ir_or, 1'b0, S_RUN | S_YIN, 16'h0, 16'h4000, 5'b00000);
        add_v("or_t4", ir_or, 1'b0, S_RUN | S_ZIN, 16'h0, 16'h2000, 5'b00110);
        add_v("or_t5", ir_or, 1'b0, S_RUN | S_ZLOWOUT, 16'h8000, 16'h0, 5'b00000);

        add_fetch("mul", ir_mul);
        add_v("mul_t3", ir_mul, 1'b0, S_RUN | S_YIN, 16'h0, 16'h0020, 5'b00000);
        add_v("mul_t4", ir_mul, 1'b0, S_RUN | S_ZIN, 16'h0, 16'h0040, 5'b01110);
        add_v("mul_t5", ir_mul, 1'b0, S_RUN | S_ZLOWOUT | S_LOIN, 16'h0, 16'h0, 5'b00000);
        add_v("mul_t6", ir_mul, 1'b0, S_RUN | S_ZHIGHOUT | S_HIIN, 16'h0, 16'h0, 5'b00000);

        add_fetch("div", ir_div);
        add_v("div_t3", ir_div, 1'b0, S_RUN | S_YIN, 16'h0, 16'h8000, 5'b00000);
        add_v("div_t4", ir_div, 1'b0, S_RUN | S_ZIN, 16'h0, 16'h0001, 5'b01111);
        add_v("div_t5", ir_div, 1'b0, S_RUN | S_ZLOWOUT | S_LOIN, 16'h0, 16'h0, 5'b00000);
        add_v("div_t6", ir_div, 1'b0, S_RUN | S_ZHIGHOUT | S_HIIN, 16'h0, 16'h0, 5'b00000);

        add_fetch("ld", ir_ld);
        add_v("ld_t3", ir_ld, 1'b0, S_RUN | S_YIN, 16'h0, 16'h0080, 5'b00000);
        add_v("ld_t4", ir_ld, 1'b0, S_RUN | S_COUT | S_ZIN, 16'h0, 16'h0, 5'b00011);
        add_v("ld_t5", ir_ld, 1'b0, S_RUN | S_ZLOWOUT | S_MARIN, 16'h0, 16'h0, 5'b00000);
        add_v("ld_t6", ir_ld, 1'b0, S_RUN | S_READ | S_MDRIN, 16'h0, 16'h0, 5'b00000);
        add_v("ld_t7", ir_ld, 1'b0, S_RUN | S_MDROUT, 16'h0004, 16'h0, 5'b00000);

        add_fetch("st", ir_st);
        add_v("st_t3", ir_st, 1'b0, S_RUN | S_YIN, 16'h0, 16'h0001, 5'b00000);
        add_v("st_t4", ir_st, 1'b0, S_RUN | S_COUT | S_ZIN, 16'h0, 16'h0, 5'b00011);
        add_v("st_t5", ir_st, 1'b0, S_RUN | S_ZLOWOUT | S_MARIN, 16'h0, 16'h0, 5'b00000);
        add_v("st_t6", ir_st, 1'b0, S_RUN | S_MDRIN, 16'h0, 16'h0200, 5'b00000);
        add_v("st_t7", ir_st, 1'b0, S_RUN | S_WRITE, 16'h0, 16'h0, 5'b00000);

        // nop with a Stop pulse that is gone again before the boundary.
        add_v("nop_t0", ir_nop, 1'b0, S_RUN | S_PCOUT | S_MARIN | S_ZIN, 16'h0, 16'h0, 5'b10100);
        add_v("nop_t1", ir_nop, 1'b1, S_RUN | S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN, 16'h0, 16'h0, 5'b00000);
        add_v("nop_t2", ir_nop, 1'b1, S_RUN | S_MDROUT | S_IRIN, 16'h0, 16'h0, 5'b00000);
        add_v("nop_t3", ir_nop, 1'b0, S_RUN, 16'h0, 16'h0, 5'b00000);

        add_fetch("und", ir_und);
        add_v("und_t3", ir_und, 1'b0, S_RUN, 16'h0, 16'h0, 5'b00000);

        // add with Stop raised in T4: completes, then halts at the boundary.
        add_fetch("stop", ir_add2);
        add_v("stop_t3", ir_add2, 1'b0, S_RUN | S_YIN, 16'h0, 16'h0004, 5'b00000);
        add_v("stop_t4", ir_add2, 1'b1, S_RUN | S_ZIN, 16'h0, 16'h0400, 5'b00011);
        add_v("stop_t5", ir_add2, 1'b1, S_RUN | S_ZLOWOUT, 16'h0040, 16'h0, 5'b00000);
        add_v("stop_halt0", ir_add2, 1'b0, 16'h0, 16'h0, 16'h0, 5'b00000);
        add_v("stop_halt1", ir_add2, 1'b0, 16'h0, 16'h0, 16'h0, 5'b00000);

        // Reset state
        clr  = 1'b0;
        Stop = 1'b0;
        IR   = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check_outs("reset_idle", 16'h0, 16'h0, 16'h0, 5'b00000);
        @(negedge clk);
        clr = 1'b1;

        run_table();

        // Reset in the middle of ld (T5), then restart from T0.
        @(negedge clk);
        clr = 1'b0;
        #1;
        check_outs("rst2_assert", 16'h0, 16'h0, 16'h0, 5'b00000);
        @(negedge clk);
        IR  = ir_ld;
        clr = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check_outs("rst2_ld_t5", S_RUN | S_ZLOWOUT | S_MARIN, 16'h0, 16'h0, 5'b00000);
        #2;
        clr = 1'b0;
        #1;
        check_outs("rst_mid_ld", 16'h0, 16'h0, 16'h0, 5'b00000);
        @(negedge clk);
        #1;
        check_outs("rst_mid_hold", 16'h0, 16'h0, 16'h0, 5'b00000);
        clr = 1'b1;
        @(negedge clk);
        #1;
        check_outs("rst_rel_t0", S_RUN | S_PCOUT | S_MARIN | S_ZIN, 16'h0, 16'h0, 5'b10100);
        @(negedge clk);
        #1;
        check_outs("rst_rel_t1", S_RUN | S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN, 16'h0, 16'h0, 5'b00000);

        // halt opcode: T3 with no strobes, then HALT for good.
        @(negedge clk);
        IR = ir_halt;
        #1;
        check_outs("halt_t2", S_RUN | S_MDROUT | S_IRIN, 16'h0, 16'h0, 5'b00000);
        @(negedge clk);
        #1;
        check_outs("halt_t3", S_RUN, 16'h0, 16'h0, 5'b00000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check_outs("halt_state", 16'h0, 16'h0, 16'h0, 5'b00000);
        end

        // Constant-field sign extension.
        IR = ir_ld;
        #1;
        check_csx("csx_neg1", 32'hFFFFFFFF);
        IR = ir_st;
        #1;
        check_csx("csx_pos10", 32'h00000010);
        IR = mk_ir(5'b00000, 4'd0, 4'd0, 19'h40000);
        #1;
        check_csx("csx_minneg", 32'hFFFC0000);
        IR = mk_ir(5'b00000, 4'd0, 4'd0, 19'h3FFFF);
        #1;
        check_csx("csx_maxpos", 32'h0003FFFF);

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
